// File: rtl/setpoint_editor.sv
// setpoint_editor
//   Turns one-clock button strobes (mode / plus / minus / button_4) into
//   operator-edited actuator setpoints. NUM_CH committed setpoints are held,
//   plus one working copy that is edited and then committed or discarded.
//
//   Optional feature macro: SETPOINT_EDITOR_ACCEL_EN
//     When defined, a run of same-direction plus/minus strobes, each arriving
//     within 200 ms of the previous one, switches to a 10*STEP step after
//     8 run strobes. When undefined, no run tracking logic is built.
//
// Ports
//   clk_i         system clock
//   nReset_i      asynchronous active-low reset
//   mode_i        strobe: advance to next channel (discards an edit)
//   plus_i        strobe: increase working value
//   minus_i       strobe: decrease working value
//   button_4_i    strobe: commit working value to the selected channel
//   sel_o         currently selected channel
//   edit_value_o  working value (tracks committed value when not editing)
//   editing_o     high while an edit is in progress
//   setpoints_o   committed setpoints, channel 0 in the LSBs
//   apply_o       one-cycle pulse when a commit updates setpoints_o
module setpoint_editor #(
    parameter int unsigned CLOCK_PERIOD_NS = 20,
    parameter int unsigned WIDTH           = 12,
    parameter int unsigned NUM_CH          = 3,
    parameter int unsigned MIN_VALUE       = 0,
    parameter int unsigned MAX_VALUE       = 4000,
    parameter int unsigned STEP            = 10,
    parameter int unsigned DEFAULT_VALUE   = 0,
    parameter int unsigned TIMEOUT_MS      = 5000
) (
    input  logic                      clk_i,
    input  logic                      nReset_i,
    input  logic                      mode_i,
    input  logic                      plus_i,
    input  logic                      minus_i,
    input  logic                      button_4_i,
    output logic [$clog2(NUM_CH)-1:0] sel_o,
    output logic [WIDTH-1:0]          edit_value_o,
    output logic                      editing_o,
    output logic [NUM_CH*WIDTH-1:0]   setpoints_o,
    output logic                      apply_o
);

    localparam int unsigned SEL_W = $clog2(NUM_CH);

    localparam longint unsigned TIMEOUT_RAW =
        64'(TIMEOUT_MS) * 64'd1000000 / 64'(CLOCK_PERIOD_NS);
    localparam longint unsigned TIMEOUT_CYCLES =
        (TIMEOUT_RAW == 64'd0) ? 64'd1 : TIMEOUT_RAW;
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 64'd1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 64'd1);

    // Signed headroom so that base +/- (10*STEP) never wraps before clamping.
    localparam int unsigned VW = WIDTH + 8;
    localparam logic signed [VW-1:0] STEP_S      = VW'(STEP);
    localparam logic signed [VW-1:0] STEP_FAST_S = VW'(10 * STEP);
    localparam logic signed [VW-1:0] MAX_S       = VW'(MAX_VALUE);
    localparam logic signed [VW-1:0] MIN_S       = VW'(MIN_VALUE);

    localparam logic [WIDTH-1:0] MAX_W    = WIDTH'(MAX_VALUE);
    localparam logic [WIDTH-1:0] MIN_W    = WIDTH'(MIN_VALUE);
    localparam logic [WIDTH-1:0] DEF_W    = WIDTH'(DEFAULT_VALUE);
    localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(NUM_CH - 1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_EDIT = 1'b1
    } state_t;

    state_t                    state_q, state_d;
    logic [SEL_W-1:0]          sel_q, sel_d;
    logic [WIDTH-1:0]          edit_q, edit_d;
    logic [NUM_CH*WIDTH-1:0]   sp_q, sp_d;
    logic                      apply_q, apply_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;

    logic                      pm_any, plus_only, minus_only;
    logic                      pm_enter, pm_accept, fast;
    logic [SEL_W-1:0]          sel_inc;
    logic [WIDTH-1:0]          cur_sp, pm_base, pm_value;
    logic signed [VW-1:0]      step_s;

    function automatic logic [WIDTH-1:0] sat_step(
        input logic [WIDTH-1:0]    base,
        input logic                up,
        input logic signed [VW-1:0] step
    );
        logic signed [VW-1:0] ext;
        logic signed [VW-1:0] res;
        ext = $signed({{(VW-WIDTH){1'b0}}, base});
        res = up ? (ext + step) : (ext - step);
        if (res > MAX_S)
            sat_step = MAX_W;
        else if (res < MIN_S)
            sat_step = MIN_W;
        else
            sat_step = res[WIDTH-1:0];
    endfunction

    assign pm_any     = plus_i | minus_i;
    assign plus_only  = plus_i & ~minus_i;
    assign minus_only = minus_i & ~plus_i;

    // button_4 and mode outrank plus/minus, so a step is only taken when both are low.
    assign pm_enter  = (state_q == S_IDLE) & ~button_4_i & ~mode_i & pm_any;
    assign pm_accept = (state_q == S_EDIT) & ~button_4_i & ~mode_i & pm_any;

    assign sel_inc = (sel_q == SEL_LAST) ? '0 : sel_q + 1'b1;
    assign cur_sp  = sp_q[sel_q*WIDTH +: WIDTH];
    assign pm_base = (state_q == S_IDLE) ? cur_sp : edit_q;
    assign step_s  = fast ? STEP_FAST_S : STEP_S;

    // plus and minus together leave the value unchanged.
    assign pm_value = plus_only  ? sat_step(pm_base, 1'b1, step_s) :
                      minus_only ? sat_step(pm_base, 1'b0, step_s) :
                                   pm_base;

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        edit_d  = edit_q;
        sp_d    = sp_q;
        apply_d = 1'b0;
        cnt_d   = cnt_q;

        case (state_q)
            S_IDLE: begin
                if (!button_4_i) begin
                    if (mode_i) begin
                        sel_d = sel_inc;
                    end else if (pm_any) begin
                        state_d = S_EDIT;
                        cnt_d   = '0;
                        edit_d  = pm_value;
                    end
                end
            end
            S_EDIT: begin
                if (button_4_i) begin
                    sp_d[sel_q*WIDTH +: WIDTH] = edit_q;
                    apply_d = 1'b1;
                    state_d = S_IDLE;
                end else if (mode_i) begin
                    sel_d   = sel_inc;
                    state_d = S_IDLE;
                end else if (pm_any) begin
                    cnt_d  = '0;
                    edit_d = pm_value;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Outside an edit the working copy mirrors the committed value of
        // whatever channel is selected after this edge.
        if (state_d == S_IDLE) begin
            cnt_d  = '0;
            edit_d = sp_d[sel_d*WIDTH +: WIDTH];
        end
    end

    always_ff @(posedge clk_i or negedge nReset_i) begin
        if (!nReset_i) begin
            state_q <= S_IDLE;
            sel_q   <= '0;
            edit_q  <= DEF_W;
            sp_q    <= {NUM_CH{DEF_W}};
            apply_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            edit_q  <= edit_d;
            sp_q    <= sp_d;
            apply_q <= apply_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef SETPOINT_EDITOR_ACCEL_EN
    localparam longint unsigned GAP_CYCLES =
        64'd200 * 64'd1000000 / 64'(CLOCK_PERIOD_NS);

    logic [3:0] run_q, run_d;
    logic       dir_q, dir_d;
    logic       same_dir, in_gap;

    // Inside EDIT only plus/minus keep the edit alive, so the inactivity
    // counter doubles as the time since the previous plus/minus strobe.
    assign same_dir = (plus_only & dir_q) | (minus_only & ~dir_q);
    assign in_gap   = 64'(cnt_q) < GAP_CYCLES;
    assign fast     = pm_accept & same_dir & in_gap & (run_q >= 4'd8);

    always_comb begin
        run_d = run_q;
        dir_d = dir_q;
        if (state_d != S_EDIT) begin
            run_d = '0;
        end else if (pm_enter) begin
            run_d = (plus_only | minus_only) ? 4'd1 : 4'd0;
            dir_d = plus_only;
        end else if (pm_accept) begin
            dir_d = plus_only;
            if (!(plus_only | minus_only))
                run_d = '0;
            else if (same_dir & in_gap)
                run_d = (run_q >= 4'd8) ? 4'd8 : run_q + 4'd1;
            else
                run_d = 4'd1;
        end
    end

    always_ff @(posedge clk_i or negedge nReset_i) begin
        if (!nReset_i) begin
            run_q <= '0;
            dir_q <= 1'b0;
        end else begin
            run_q <= run_d;
            dir_q <= dir_d;
        end
    end
`else
    assign fast = 1'b0;
`endif

    assign sel_o        = sel_q;
    assign edit_value_o = edit_q;
    assign editing_o    = (state_q == S_EDIT);
    assign setpoints_o  = sp_q;
    assign apply_o      = apply_q;

endmodule

// File: tb/tb_setpoint_editor.sv
// tb_setpoint_editor
//   Directed bench for setpoint_editor with hand-computed expected values.
//   Timing parameters are chosen so the inactivity timeout is 1000 cycles in
//   both builds; with SETPOINT_EDITOR_ACCEL_EN one cycle represents 1 ms so
//   that 150 ms / 200 ms / 300 ms spacings map to whole cycle counts.
module tb_setpoint_editor;

`ifdef SETPOINT_EDITOR_ACCEL_EN
    localparam int unsigned CLK_NS = 1000000;
    localparam int unsigned TMO_MS = 1000;
`else
    localparam int unsigned CLK_NS = 1000;
    localparam int unsigned TMO_MS = 1;
`endif
    localparam int T = 1000;

    logic        clk;
    logic        n_reset;
    logic        mode, plus, minus, button_4;
    logic [1:0]  sel;
    logic [11:0] edit_value;
    logic        editing;
    logic [35:0] setpoints;
    logic        apply;

    int checks = 0;
    int errors = 0;

    setpoint_editor #(
        .CLOCK_PERIOD_NS(CLK_NS),
        .WIDTH(12),
        .NUM_CH(3),
        .MIN_VALUE(0),
        .MAX_VALUE(4000),
        .STEP(10),
        .DEFAULT_VALUE(0),
        .TIMEOUT_MS(TMO_MS)
    ) dut (
        .clk_i(clk),
        .nReset_i(n_reset),
        .mode_i(mode),
        .plus_i(plus),
        .minus_i(minus),
        .button_4_i(button_4),
        .sel_o(sel),
        .edit_value_o(edit_value),
        .editing_o(editing),
        .setpoints_o(setpoints),
        .apply_o(apply)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One-clock strobe; returns on the falling edge after the registering edge.
    task automatic strobe(input logic m, input logic p, input logic n, input logic b);
        @(negedge clk);
        mode = m; plus = p; minus = n; button_4 = b;
        @(negedge clk);
        mode = 1'b0; plus = 1'b0; minus = 1'b0; button_4 = 1'b0;
    endtask

    task automatic idle(input int k);
        repeat (k) @(negedge clk);
    endtask

    task automatic ramp_to_3990();
`ifdef SETPOINT_EDITOR_ACCEL_EN
        // 8 strobes of 10 then 39 fast strobes of 100 -> 3980; a broken run adds 10.
        repeat (47) strobe(0, 1, 0, 0);
        check("ramp_fast", edit_value, 3980);
        idle(250);
        strobe(0, 1, 0, 0);
`else
        repeat (399) strobe(0, 1, 0, 0);
`endif
    endtask

    int exp_acc[10] = '{10, 20, 30, 40, 50, 60, 70, 80, 180, 280};

    initial begin
        n_reset = 1'b0;
        mode = 1'b0; plus = 1'b0; minus = 1'b0; button_4 = 1'b0;
        idle(3);
        n_reset = 1'b1;
        idle(1);

        check("rst_sel", sel, 0);
        check("rst_edit", edit_value, 0);
        check("rst_editing", editing, 0);
        check("rst_apply", apply, 0);
        check("rst_setpoints", setpoints, 0);

        // plus x3 on channel 0, then commit
        strobe(0, 1, 0, 0); check("p1", edit_value, 10); check("p1_editing", editing, 1);
        strobe(0, 1, 0, 0); check("p2", edit_value, 20);
        strobe(0, 1, 0, 0); check("p3", edit_value, 30);
        strobe(0, 0, 0, 1);
        check("commit_ch0", setpoints[11:0], 30);
        check("commit_apply", apply, 1);
        check("commit_editing", editing, 0);
        idle(1);
        check("apply_one_cycle", apply, 0);

        // channel selection wraps
        strobe(1, 0, 0, 0); check("sel1", sel, 1);
        strobe(1, 0, 0, 0); check("sel2", sel, 2);
        strobe(1, 0, 0, 0); check("sel0", sel, 0);
        check("sel0_edit", edit_value, 30);

        // mode during an edit discards it
        strobe(0, 1, 0, 0); strobe(0, 1, 0, 0);
        check("edit50", edit_value, 50);
        strobe(1, 0, 0, 0);
        check("mode_edit_sel", sel, 1);
        check("mode_edit_editing", editing, 0);
        check("mode_edit_apply", apply, 0);
        check("mode_edit_ch0", setpoints[11:0], 30);
        check("mode_edit_value", edit_value, 0);

        // upper bound on channel 1
        ramp_to_3990();
        check("ramp", edit_value, 3990);
        strobe(0, 1, 0, 0); check("max1", edit_value, 4000);
        strobe(0, 1, 0, 0); check("max2", edit_value, 4000);
        strobe(0, 0, 0, 1);
        check("commit_ch1", setpoints[23:12], 4000);
        check("commit_ch1_apply", apply, 1);

        // lower bound on channel 2; committing an unchanged value still applies
        strobe(1, 0, 0, 0); check("sel_ch2", sel, 2); check("ch2_edit", edit_value, 0);
        strobe(0, 1, 0, 0); check("ch2_up", edit_value, 10);
        strobe(0, 0, 1, 0); check("min1", edit_value, 0);
        strobe(0, 0, 1, 0); check("min2", edit_value, 0);
        strobe(0, 0, 0, 1);
        check("commit_ch2", setpoints[35:24], 0);
        check("commit_ch2_apply", apply, 1);

        // inactivity timeout on channel 0
        strobe(1, 0, 0, 0); check("sel_wrap", sel, 0);
        strobe(0, 1, 0, 0); check("tmo_start", edit_value, 40);
        idle(T - 1);
        check("tmo_before", editing, 1);
        idle(1);
        check("tmo_editing", editing, 0);
        check("tmo_revert", edit_value, 30);
        check("tmo_apply", apply, 0);
        check("tmo_ch0", setpoints[11:0], 30);

        // plus+minus together: value held, timeout restarted
        strobe(0, 1, 0, 0);
        idle(500);
        strobe(0, 1, 1, 0);
        check("pm_value", edit_value, 40);
        idle(T - 1);
        check("pm_restart", editing, 1);
        idle(1);
        check("pm_timeout", editing, 0);
        check("pm_revert", edit_value, 30);

        // button_4 outranks plus in EDIT; mode outranks plus in IDLE
        strobe(0, 1, 0, 0);
        strobe(0, 1, 0, 1);
        check("prio_commit", setpoints[11:0], 40);
        check("prio_apply", apply, 1);
        check("prio_edit", edit_value, 40);
        strobe(1, 1, 0, 0);
        check("prio_mode_sel", sel, 1);
        check("prio_mode_editing", editing, 0);

        // button_4 in IDLE does nothing
        strobe(0, 0, 0, 1);
        check("idle_b4_apply", apply, 0);
        check("idle_b4_ch1", setpoints[23:12], 4000);

        // asynchronous reset mid-edit
        strobe(0, 1, 0, 0);
        check("pre_rst_editing", editing, 1);
        @(negedge clk);
        #2 n_reset = 1'b0;
        #1;
        check("async_editing", editing, 0);
        check("async_sel", sel, 0);
        check("async_edit", edit_value, 0);
        check("async_setpoints", setpoints, 0);
        check("async_apply", apply, 0);
        @(negedge clk);
        n_reset = 1'b1;

`ifdef SETPOINT_EDITOR_ACCEL_EN
        // held button: strobes 150 cycles (150 ms) apart
        for (int i = 0; i < 10; i++) begin
            if (i > 0) idle(148);
            strobe(0, 1, 0, 0);
            check($sformatf("accel%0d", i), edit_value, exp_acc[i]);
        end
        idle(298);
        strobe(0, 1, 0, 0);
        check("accel_gap", edit_value, 290);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
